// File: rtl/ahb_arbiter_nm.sv
// N-master AHB arbiter: fixed-priority or round-robin grant, fixed-burst / INCR / locked-sequence protection.
// Hgrant moves on arbitration edges; Hmaster/Hmastlock follow one accepted (Hready=1) edge later.
module ahb_arbiter_nm #(
  parameter int NUM_MASTERS    = 4,
  parameter int MODE           = 1,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   Hclk,
  input  logic                   Hresetn,
  input  logic [NUM_MASTERS-1:0] Hreq,
  input  logic [NUM_MASTERS-1:0] Hlock,
  input  logic                   Hready,
  input  logic [1:0]             Htrans,
  input  logic [2:0]             Hburst,
  output logic [NUM_MASTERS-1:0] Hgrant,
  output logic [MW-1:0]          Hmaster,
  output logic                   Hmastlock
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] BU_INCR   = 3'd1;

  localparam logic [MW-1:0]          DEF_IDX    = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  typedef enum logic [1:0] {
    ST_OPEN,
    ST_BURST,
    ST_INCR_HOLD,
    ST_LOCKED
  } state_t;

  state_t                   state_reg, state_next;
  logic [4:0]               cnt_reg, cnt_next;
  logic [NUM_MASTERS-1:0]   grant_reg;
  logic [MW-1:0]            grant_idx_reg;
  logic [MW-1:0]            hmaster_reg;
  logic                     hmastlock_reg;
  logic [MW-1:0]            rr_ptr_reg;

  logic                     owner_req, owner_lock;
  logic                     incr_next, arb_point;
  logic [NUM_MASTERS-1:0]   above_ptr, req_above;
  logic [MW-1:0]            winner;
  logic [NUM_MASTERS-1:0]   winner_onehot;

  // The grant holder is the "owner" for hold/lock decisions.
  assign owner_req  = Hreq[grant_idx_reg];
  assign owner_lock = Hlock[grant_idx_reg];

  function automatic logic [MW-1:0] lowest_set(input logic [NUM_MASTERS-1:0] v);
    lowest_set = DEF_IDX;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (v[k]) lowest_set = MW'(k);
    end
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign above_ptr[gi]     = (MW'(gi) > rr_ptr_reg);
      assign winner_onehot[gi] = (winner == MW'(gi));
    end
  endgenerate

  assign req_above = Hreq & above_ptr;

  // Remaining address phases of a fixed-length burst.
  always_comb begin
    cnt_next = cnt_reg;
    case (Htrans)
      TR_IDLE: cnt_next = 5'd0;
      TR_BUSY: cnt_next = cnt_reg;
      TR_NONSEQ: begin
        case (Hburst)
          3'd2, 3'd3: cnt_next = 5'd3;
          3'd4, 3'd5: cnt_next = 5'd7;
          3'd6, 3'd7: cnt_next = 5'd15;
          default:    cnt_next = 5'd0;
        endcase
      end
      default: cnt_next = (cnt_reg == 5'd0) ? 5'd0 : cnt_reg - 5'd1;
    endcase
  end

  always_comb begin
    state_next = ST_OPEN;
    incr_next  = 1'b0;
    case (Htrans)
      TR_NONSEQ:      incr_next = (Hburst == BU_INCR);
      TR_SEQ, TR_BUSY: incr_next = (state_reg == ST_INCR_HOLD);
      default:        incr_next = 1'b0;
    endcase
    if (owner_lock)
      state_next = ST_LOCKED;
    else if (cnt_next != 5'd0)
      state_next = ST_BURST;
    else if (incr_next && owner_req)
      state_next = ST_INCR_HOLD;
  end

  assign arb_point = Hready && (state_next == ST_OPEN);

  // Round robin: first requester above the pointer, else wrap to the lowest requester.
  always_comb begin
    winner = DEF_IDX;
    if (|Hreq) begin
      if (MODE == 0)
        winner = lowest_set(Hreq);
      else if (|req_above)
        winner = lowest_set(req_above);
      else
        winner = lowest_set(Hreq);
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_reg     <= ST_OPEN;
      cnt_reg       <= 5'd0;
      grant_reg     <= DEF_ONEHOT;
      grant_idx_reg <= DEF_IDX;
      hmaster_reg   <= DEF_IDX;
      hmastlock_reg <= 1'b0;
      rr_ptr_reg    <= DEF_IDX;
    end else if (Hready) begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      hmaster_reg   <= grant_idx_reg;
      hmastlock_reg <= owner_lock;
      if (arb_point) begin
        grant_reg     <= winner_onehot;
        grant_idx_reg <= winner;
        if (|Hreq) rr_ptr_reg <= winner;
      end
    end
  end

  assign Hgrant    = grant_reg;
  assign Hmaster   = hmaster_reg;
  assign Hmastlock = hmastlock_reg;

endmodule

// File: tb/tb_ahb_arbiter_nm.sv
// Bench for ahb_arbiter_nm: a fixed-priority and a round-robin instance share stimulus and are
// compared every cycle against a behavioural model, plus directed expectations.
module tb_ahb_arbiter_nm;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic         Hclk = 1'b0;
  logic         Hresetn;
  logic         Hready;
  logic [N-1:0] Hreq;
  logic [N-1:0] Hlock;
  logic [1:0]   Htrans;
  logic [2:0]   Hburst;

  logic [N-1:0] grant_fp, grant_rr;
  logic [1:0]   hm_fp, hm_rr;
  logic         ml_fp, ml_rr;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = fixed priority, 1 = round robin.
  int m_grant[2];
  int m_hm[2];
  int m_rem[2];
  int m_rr[2];
  bit m_ml[2];
  bit m_incr[2];

  always #5 Hclk = ~Hclk;

  ahb_arbiter_nm #(.NUM_MASTERS(N), .MODE(0), .DEFAULT_MASTER(DEF)) dut_fp (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hreq(Hreq), .Hlock(Hlock), .Hready(Hready),
    .Htrans(Htrans), .Hburst(Hburst), .Hgrant(grant_fp), .Hmaster(hm_fp), .Hmastlock(ml_fp)
  );

  ahb_arbiter_nm #(.NUM_MASTERS(N), .MODE(1), .DEFAULT_MASTER(DEF)) dut_rr (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hreq(Hreq), .Hlock(Hlock), .Hready(Hready),
    .Htrans(Htrans), .Hburst(Hburst), .Hgrant(grant_rr), .Hmaster(hm_rr), .Hmastlock(ml_rr)
  );

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int burst_beats(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_grant[d] = DEF;
      m_hm[d]    = DEF;
      m_rem[d]   = 0;
      m_rr[d]    = DEF;
      m_ml[d]    = 1'b0;
      m_incr[d]  = 1'b0;
    end
  endtask

  // One accepted bus edge, evaluated from the arbitration rules with plain integers.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int g, rem, w, c;
      bit incr, lk, open;
      g   = m_grant[d];
      rem = m_rem[d];
      case (Htrans)
        2'd0:    rem = 0;
        2'd2:    rem = burst_beats(Hburst) - 1;
        2'd3:    rem = (rem > 0) ? rem - 1 : 0;
        default: rem = rem;
      endcase
      if (Htrans == 2'd2)      incr = (Hburst == 3'd1);
      else if (Htrans == 2'd0) incr = 1'b0;
      else                     incr = m_incr[d];
      lk   = Hlock[g];
      incr = incr && Hreq[g] && !lk;
      open = !lk && (rem == 0) && !incr;
      m_hm[d]   = g;
      m_ml[d]   = lk;
      m_rem[d]  = rem;
      m_incr[d] = incr;
      if (open) begin
        w = -1;
        if (Hreq == '0) begin
          w = DEF;
        end else if (d == 0) begin
          for (int k = 0; k < N; k++)
            if (Hreq[k] && w < 0) w = k;
        end else begin
          for (int k = 1; k <= N; k++) begin
            c = (m_rr[d] + k) % N;
            if (Hreq[c] && w < 0) w = c;
          end
          m_rr[d] = w;
        end
        m_grant[d] = w;
      end
    end
  endtask

  task automatic check_all();
    chk4("grant_fp", grant_fp, 4'(1 << m_grant[0]));
    chk2("hmaster_fp", hm_fp, 2'(m_hm[0]));
    chk1("mastlock_fp", ml_fp, m_ml[0]);
    chk1("onehot_fp", $onehot(grant_fp), 1'b1);
    chk4("grant_rr", grant_rr, 4'(1 << m_grant[1]));
    chk2("hmaster_rr", hm_rr, 2'(m_hm[1]));
    chk1("mastlock_rr", ml_rr, m_ml[1]);
    chk1("onehot_rr", $onehot(grant_rr), 1'b1);
  endtask

  task automatic tick();
    @(posedge Hclk);
    if (!Hresetn)    model_reset();
    else if (Hready) model_edge();
    #1;
    check_all();
  endtask

  // Reset pulse landing mid-cycle, checked before any clock edge.
  task automatic async_reset();
    #3;
    Hresetn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk4("async_rst_grant", grant_rr, 4'b0001);
    chk2("async_rst_hmaster", hm_rr, 2'd0);
    chk1("async_rst_mastlock", ml_rr, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    model_reset();
    Hresetn = 1'b0; Hready = 1'b1; Hreq = '0; Hlock = '0; Htrans = 2'd0; Hburst = 3'd0;
    tick();
    chk4("rst_grant", grant_rr, 4'b0001);
    chk2("rst_hmaster", hm_rr, 2'd0);
    chk1("rst_mastlock", ml_rr, 1'b0);
    Hresetn = 1'b1;
    repeat (2) tick();
    chk4("noreq_grant_rr", grant_rr, 4'b0001);
    chk4("noreq_grant_fp", grant_fp, 4'b0001);

    // Fixed priority and preemption
    Hreq = 4'b1010;
    tick();
    chk4("fp_grant1", grant_fp, 4'b0010);
    chk2("fp_hm_lag", hm_fp, 2'd0);
    tick();
    chk2("fp_hm1", hm_fp, 2'd1);
    Hreq = 4'b1011;
    tick();
    chk4("fp_preempt0", grant_fp, 4'b0001);

    // Round-robin rotation with single transfers
    Hresetn = 1'b0;
    tick();
    Hresetn = 1'b1;
    Hreq = 4'b1111; Htrans = 2'd2; Hburst = 3'd0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk4("rr_rotate", grant_rr, 4'(1 << (i % 4)));
    end

    // Master 2 INCR8 with a 3-cycle wait state mid-burst
    Htrans = 2'd0; Hreq = 4'b0100;
    repeat (2) tick();
    chk2("burst_owner_hm", hm_rr, 2'd2);
    Hreq = 4'b1111; Htrans = 2'd2; Hburst = 3'd5;
    tick();
    chk4("burst_beat1", grant_rr, 4'b0100);
    for (int b = 2; b <= 8; b++) begin
      Htrans = 2'd3;
      if (b == 5) begin
        Hready = 1'b0;
        repeat (3) begin
          tick();
          chk4("burst_stall", grant_rr, 4'b0100);
        end
        Hready = 1'b1;
      end
      tick();
      chk4("burst_beat", grant_rr, (b < 8) ? 4'b0100 : 4'b1000);
    end
    chk4("burst_end_fp", grant_fp, 4'b0001);

    // INCR4 terminated early by IDLE
    Htrans = 2'd0; Hreq = 4'b0010;
    repeat (2) tick();
    Hreq = 4'b1111; Htrans = 2'd2; Hburst = 3'd3;
    tick();
    chk4("early_b1", grant_rr, 4'b0010);
    Htrans = 2'd3;
    tick();
    chk4("early_b2", grant_rr, 4'b0010);
    Htrans = 2'd0;
    tick();
    chk4("early_release", grant_rr, 4'b0100);

    // Locked sequence by master 1
    Hreq = 4'b0010; Hlock = 4'b0010;
    repeat (2) tick();
    Hreq = 4'b1111; Htrans = 2'd2; Hburst = 3'd0;
    repeat (3) begin
      tick();
      chk4("lock_hold_rr", grant_rr, 4'b0010);
      chk4("lock_hold_fp", grant_fp, 4'b0010);
      chk1("lock_mastlock", ml_rr, 1'b1);
    end
    Hlock = 4'b0000;
    tick();
    chk1("lock_drop", ml_rr, 1'b0);
    chk4("lock_release", grant_rr, 4'b0100);
    Hlock = 4'b0001;
    tick();
    chk4("lock_nonowner", grant_rr, 4'b1000);
    Hlock = 4'b0000;

    // Reset in the middle of an INCR16
    Hreq = 4'b1000; Htrans = 2'd0;
    repeat (2) tick();
    Hreq = 4'b1111; Htrans = 2'd2; Hburst = 3'd7;
    tick();
    Htrans = 2'd3;
    repeat (3) begin
      tick();
      chk4("incr16_hold", grant_rr, 4'b1000);
    end
    async_reset();
    tick();
    Hresetn = 1'b1;
    tick();
    chk4("post_reset_cnt0", grant_rr, 4'b0010);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      Hready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) Hreq = 4'($urandom);
      Hlock = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      t = int'($urandom_range(0, 9));
      Htrans = (t == 0) ? 2'd0 : (t == 1) ? 2'd1 : (t == 2) ? 2'd2 : 2'd3;
      Hburst = 3'($urandom);
      tick();
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        #1;
        Hresetn = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
